// File: rtl/ccip_arb_pkg.sv
// Shared constants and helpers for the CCI-P c0 round-robin arbiter.
// The source-port tag occupies mdata[TAG_MSB -: port_bits(NUM_PORTS)].
package ccip_arb_pkg;

   localparam int unsigned TAG_MSB   = 15;
   localparam int unsigned MAX_PORTS = 16;

   function automatic int unsigned port_bits(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [port_bits(MAX_PORTS)-1:0] t_arb_port_idx;

endpackage

// File: rtl/ccip_if_pkg.sv
// CCI-P c0 channel header types used by the read-channel arbiter.
// Field layout follows the CCI-P request/response header ordering, mdata in the low 16 bits.
package ccip_if_pkg;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  rsvd1;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

endpackage

// File: rtl/ccip_arb_fifo.sv
// Per-port synchronous request FIFO with occupancy count and a sticky overflow flag.
// Pushes into a full FIFO are dropped; the head entry is read combinationally.
module ccip_arb_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 74
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         // Debug-only: records that a port ignored almFull and lost a request.
         if (i_push && w_full) r_overflow <= 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ccip_c0_rr_arbiter.sv
// N-port round-robin arbiter for the CCI-P c0 read channel: per-port FIFOs, source tag in mdata,
// tag-routed responses. Optional per-port outstanding-read credits via `define CCIP_ARB_CREDIT_EN.
module ccip_c0_rr_arbiter
   import ccip_if_pkg::*;
   import ccip_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned ALMFULL_SLACK   = 4,
   parameter int unsigned MAX_OUTSTANDING = 64
) (
   input  logic                  pClk,
   input  logic                  SoftReset_n,
   input  logic [NUM_PORTS-1:0]  port_c0_valid,
   input  t_ccip_c0_ReqMemHdr    port_c0_hdr [NUM_PORTS],
   output logic [NUM_PORTS-1:0]  port_c0_almFull,
   output logic                  up_c0_valid,
   output t_ccip_c0_ReqMemHdr    up_c0_hdr,
   input  logic                  up_c0_almFull,
   input  logic                  up_rx_rspValid,
   input  t_ccip_c0_RspMemHdr    up_rx_hdr,
   input  logic [511:0]          up_rx_data,
   output logic [NUM_PORTS-1:0]  port_rx_rspValid,
   output t_ccip_c0_RspMemHdr    port_rx_hdr,
   output logic [511:0]          port_rx_data
);
   localparam int unsigned PORT_BITS = port_bits(NUM_PORTS);
   localparam int unsigned HDR_W     = $bits(t_ccip_c0_ReqMemHdr);
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] ALMFULL_LVL = CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);

   logic [HDR_W-1:0]     w_head [NUM_PORTS];
   logic [CNT_W-1:0]     w_count [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_empty;
   logic [NUM_PORTS-1:0] w_pop;
   logic [NUM_PORTS-1:0] w_credit_ok;
   logic [NUM_PORTS-1:0] w_eligible;
   logic [NUM_PORTS-1:0] w_rsp_onehot;
   logic                 w_grant_vld;
   logic [PORT_BITS-1:0] w_grant_sel;
   logic [PORT_BITS-1:0] r_last_grant;
   logic [PORT_BITS-1:0] w_rsp_tag;
   t_ccip_c0_ReqMemHdr   w_grant_hdr;
   t_ccip_c0_RspMemHdr   w_rsp_hdr;

   always_comb begin
      assert (NUM_PORTS >= 2 && NUM_PORTS <= MAX_PORTS && ALMFULL_SLACK < FIFO_DEPTH &&
              FIFO_DEPTH >= 4 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0 && MAX_OUTSTANDING >= 1);
   end

   assign w_rsp_tag = up_rx_hdr.mdata[TAG_MSB -: PORT_BITS];

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      ccip_arb_fifo #(
         .DEPTH (FIFO_DEPTH),
         .WIDTH (HDR_W)
      ) u_fifo (
         .clk     (pClk),
         .rst_n   (SoftReset_n),
         .i_push  (port_c0_valid[i]),
         .i_data  (port_c0_hdr[i]),
         .i_pop   (w_pop[i]),
         .o_data  (w_head[i]),
         .o_count (w_count[i]),
         .o_empty (w_empty[i])
      );
      assign port_c0_almFull[i] = (w_count[i] >= ALMFULL_LVL);
      assign w_pop[i]           = w_grant_vld && (w_grant_sel == PORT_BITS'(i));
      // Out-of-range tags match no port and are dropped.
      assign w_rsp_onehot[i]    = up_rx_rspValid && (w_rsp_tag == PORT_BITS'(i));
   end

`ifdef CCIP_ARB_CREDIT_EN
   localparam int unsigned CRED_W = port_bits(MAX_OUTSTANDING + 1);

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_credit
      logic [CRED_W-1:0] r_outstanding;
      logic              w_inc;
      logic              w_dec;

      assign w_inc = w_pop[i];
      // Responses that outlive a reset find a zero counter and must not wrap it.
      assign w_dec = w_rsp_onehot[i] && (r_outstanding != '0);
      assign w_credit_ok[i] = (r_outstanding != CRED_W'(MAX_OUTSTANDING));

      always_ff @(posedge pClk or negedge SoftReset_n) begin
         if (!SoftReset_n) begin
            r_outstanding <= '0;
         end else begin
            case ({w_inc, w_dec})
               2'b10:   r_outstanding <= r_outstanding + CRED_W'(1);
               2'b01:   r_outstanding <= r_outstanding - CRED_W'(1);
               default: r_outstanding <= r_outstanding;
            endcase
         end
      end
   end
`else
   assign w_credit_ok = '1;
`endif

   assign w_eligible = ~w_empty & w_credit_ok;

   // Scan starts one past the last winner so every port gets a turn.
   always_comb begin : p_arb
      int unsigned v_p;
      w_grant_vld = 1'b0;
      w_grant_sel = '0;
      v_p         = 0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         v_p = 32'(r_last_grant) + k;
         if (v_p >= NUM_PORTS) v_p = v_p - NUM_PORTS;
         if (!w_grant_vld && !up_c0_almFull && w_eligible[v_p[PORT_BITS-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_sel = v_p[PORT_BITS-1:0];
         end
      end
   end

   always_comb begin
      w_grant_hdr = t_ccip_c0_ReqMemHdr'(w_head[w_grant_sel]);
      w_grant_hdr.mdata[TAG_MSB -: PORT_BITS] = w_grant_sel;
   end

   always_comb begin
      w_rsp_hdr = up_rx_hdr;
      w_rsp_hdr.mdata[TAG_MSB -: PORT_BITS] = '0;
   end

   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         r_last_grant <= PORT_BITS'(NUM_PORTS - 1);
         up_c0_valid  <= 1'b0;
         up_c0_hdr    <= '0;
      end else begin
         up_c0_valid <= w_grant_vld;
         if (w_grant_vld) begin
            r_last_grant <= w_grant_sel;
            up_c0_hdr    <= w_grant_hdr;
         end
      end
   end

   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         port_rx_rspValid <= '0;
         port_rx_hdr      <= '0;
         port_rx_data     <= '0;
      end else begin
         port_rx_rspValid <= w_rsp_onehot;
         if (up_rx_rspValid) begin
            port_rx_hdr  <= w_rsp_hdr;
            port_rx_data <= up_rx_data;
         end
      end
   end

endmodule
